// File: rtl/serial_digit_checker_if.sv
// Serial digit checker bus: gated bit stream in, framed digit
// results and saturating statistics out.
interface serial_digit_checker_if #(
    parameter int DIGIT_W = 4,
    parameter int CNT_W   = 8
);
    logic               bit_valid;
    logic               bit_in;
    logic               clear;
    logic               out_valid;
    logic               digit_ok;
    logic [DIGIT_W-1:0] digit_value;
    logic               doomed;
    logic [CNT_W-1:0]   ok_count;
    logic [CNT_W-1:0]   bad_count;

    modport master (
        output bit_valid, bit_in, clear,
        input  out_valid, digit_ok, digit_value,
        input  doomed, ok_count, bad_count
    );

    modport slave (
        input  bit_valid, bit_in, clear,
        output out_valid, digit_ok, digit_value,
        output doomed, ok_count, bad_count
    );
endinterface

// File: rtl/serial_digit_checker.sv
// Frames an MSB-first bit stream into digits, flags value < LIMIT,
// rejects hopeless prefixes early and keeps saturating tallies.
module serial_digit_checker #(
    parameter int DIGIT_W = 4,
    parameter int LIMIT   = 10,
    parameter int CNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_digit_checker_if.slave bus
);
    localparam int IW = (DIGIT_W > 2) ? $clog2(DIGIT_W) : 1;
    localparam logic [DIGIT_W:0] LIM  = (DIGIT_W+1)'(LIMIT);
    localparam logic [IW-1:0]    LAST = IW'(DIGIT_W - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, COLLECT, DOOMED} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DIGIT_W-1:0] r_sh;
    logic [IW-1:0]      r_idx;
    logic               r_out_valid;
    logic               r_ok;
    logic [DIGIT_W-1:0] r_value;
    logic [CNT_W-1:0]   r_ok_cnt;
    logic [CNT_W-1:0]   r_bad_cnt;

    logic [DIGIT_W-1:0] w_sh;
    logic [IW-1:0]      w_shamt;
    logic [DIGIT_W:0]   w_min;
    logic               w_last;
    logic               w_fail;
    logic               w_done;

    // Unreceived bits count as zero, so the padded prefix is the
    // smallest value the digit can still reach.
    always_comb begin
        w_next  = r_state;
        w_done  = 1'b0;
        w_sh    = {r_sh[DIGIT_W-2:0], bus.bit_in};
        w_shamt = LAST - r_idx;
        w_min   = {1'b0, w_sh} << w_shamt;
        w_last  = (r_idx == LAST);
        w_fail  = (w_min >= LIM);
        if (bus.clear) begin
            w_next = IDLE;
        end else if (bus.bit_valid) begin
            if (w_last) begin
                w_next = IDLE;
                w_done = 1'b1;
            end else if (w_fail || r_state == DOOMED) begin
                w_next = DOOMED;
            end else begin
                w_next = COLLECT;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sh        <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_ok        <= 1'b0;
            r_value     <= '0;
            r_ok_cnt    <= '0;
            r_bad_cnt   <= '0;
        end else if (bus.clear) begin
            r_sh        <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_ok_cnt    <= '0;
            r_bad_cnt   <= '0;
        end else begin
            r_out_valid <= w_done;
            if (bus.bit_valid) begin
                if (w_done) begin
                    r_value <= w_sh;
                    r_ok    <= !w_fail;
                    r_sh    <= '0;
                    r_idx   <= '0;
                    if (!w_fail) begin
                        if (r_ok_cnt != CMAX)
                            r_ok_cnt <= r_ok_cnt + 1'b1;
                    end else begin
                        if (r_bad_cnt != CMAX)
                            r_bad_cnt <= r_bad_cnt + 1'b1;
                    end
                end else begin
                    r_sh  <= w_sh;
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.digit_ok    = r_ok;
    assign bus.digit_value = r_value;
    assign bus.doomed      = (r_state == DOOMED);
    assign bus.ok_count    = r_ok_cnt;
    assign bus.bad_count   = r_bad_cnt;
endmodule
